// File: rtl/l2_fwd_lookup_if.sv
// Parser-side metadata stream into the L2 forwarding stage and its forwarded output.
// master = upstream/driver side, slave = the forwarding stage.
interface l2_fwd_lookup_if;
  logic         metadata_in_valid;
  logic [133:0] metadata_in;
  logic         ready_in;
  logic         tbl_clear;
  logic         metadata_out_valid;
  logic [133:0] metadata_out;
  logic         ready_out;

  modport master (
    output metadata_in_valid, metadata_in, ready_in, tbl_clear,
    input  metadata_out_valid, metadata_out, ready_out
  );

  modport slave (
    input  metadata_in_valid, metadata_in, ready_in, tbl_clear,
    output metadata_out_valid, metadata_out, ready_out
  );
endinterface

// File: rtl/l2_fwd_lookup.sv
// L2 forwarding: learns smac->port, looks up dmac, patches the egress bitmap into metadata word 0.
// 2-cycle latency per word (word 0 also waits for word 1); no internal backpressure.
module l2_fwd_lookup #(
  parameter int IDX_W     = 4,
  parameter int NUM_PORTS = 8
) (
  input logic            clk,
  input logic            reset,
  l2_fwd_lookup_if.slave bus
);

  localparam int         DEPTH     = 1 << IDX_W;
  localparam logic [7:0] PORT_MASK = 8'((16'd1 << NUM_PORTS) - 16'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_META = 2'd1,
    S_PKT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [47:0] mac;
    logic [3:0]  port;
  } ent_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_mark_hdr;

  logic [133:0]       r_s_word;
  logic               r_s_valid;
  logic               r_s_hdr;

  logic [DEPTH-1:0]   r_tbl_vld;
  ent_t               r_tbl [DEPTH];

  logic               w_in_vld;
  logic [1:0]         w_in_tag;
  logic [47:0]        w_dmac;
  logic [47:0]        w_smac;
  logic [IDX_W-1:0]   w_idx_d;
  logic [IDX_W-1:0]   w_idx_s;
  logic [3:0]         w_in_port;
  ent_t               w_ent;
  logic               w_hold;
  logic               w_hdr_out;
  logic               w_word1;
  logic               w_hit;
  logic               w_learn;
  logic [7:0]         w_excl;
  logic [7:0]         w_bitmap;
  logic [133:0]       w_out_word;

  assign w_in_vld  = bus.metadata_in_valid;
  assign w_in_tag  = bus.metadata_in[133:132];
  assign w_dmac    = bus.metadata_in[127:80];
  assign w_smac    = bus.metadata_in[79:32];
  assign w_idx_d   = w_dmac[IDX_W-1:0];
  assign w_idx_s   = w_smac[IDX_W-1:0];
  assign w_in_port = r_s_word[123:120];
  assign w_ent     = r_tbl[w_idx_d];
  assign w_word1   = (w_in_tag == 2'b11);

  // A staged word 0 is parked until word 1 shows up, since its bitmap depends on word 1.
  assign w_hold    = r_s_valid && r_s_hdr && !w_in_vld;
  assign w_hdr_out = r_s_valid && r_s_hdr && w_in_vld;
  assign w_learn   = w_hdr_out && w_word1 && !w_smac[40];

  // Stream tracker: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stream tracker: next state
  always_comb begin
    w_state_nxt = r_state;
    if (w_in_vld) begin
      case (r_state)
        S_IDLE:  if (w_in_tag == 2'b01) w_state_nxt = S_META;
        S_META:  if (w_in_tag == 2'b00) w_state_nxt = S_PKT;
        S_PKT:   if (w_in_tag == 2'b10) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Stream tracker: outputs
  always_comb begin
    w_mark_hdr = 1'b0;
    if (w_in_vld && (r_state == S_IDLE) && (w_in_tag == 2'b01)) begin
      w_mark_hdr = 1'b1;
    end
  end

  // Lookup reads pre-edge table contents; a same-cycle learn is not visible here.
  always_comb begin
    w_excl = ~(8'd1 << w_in_port);
    w_hit  = r_tbl_vld[w_idx_d] && (w_ent.mac == w_dmac) && !w_dmac[40];
    if (w_word1 && w_hit) begin
      w_bitmap = (8'd1 << w_ent.port) & w_excl & PORT_MASK;
    end else begin
      w_bitmap = PORT_MASK & w_excl;
    end
    w_out_word = r_s_word;
    if (r_s_hdr) begin
      w_out_word[119:112] = w_bitmap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s_word  <= '0;
      r_s_valid <= 1'b0;
      r_s_hdr   <= 1'b0;
    end else if (!w_hold) begin
      r_s_word  <= bus.metadata_in;
      r_s_valid <= w_in_vld;
      r_s_hdr   <= w_mark_hdr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.metadata_out_valid <= 1'b0;
      bus.metadata_out       <= '0;
      bus.ready_out          <= 1'b1;
    end else begin
      bus.ready_out <= bus.ready_in;
      if (w_hold) begin
        bus.metadata_out_valid <= 1'b0;
      end else begin
        bus.metadata_out_valid <= r_s_valid;
        bus.metadata_out       <= w_out_word;
      end
    end
  end

  // Clear first, then the learn re-validates its own index on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tbl_vld <= '0;
    end else begin
      if (bus.tbl_clear) r_tbl_vld <= '0;
      if (w_learn)       r_tbl_vld[w_idx_s] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_learn) begin
      r_tbl[w_idx_s] <= '{mac: w_smac, port: w_in_port};
    end
  end

endmodule

// File: tb/tb_l2_fwd_lookup.sv
// Directed bench for l2_fwd_lookup: table of packets with hand-computed bitmaps plus
// hand-written sequences for table clear, malformed metadata and mid-packet reset.
module tb_l2_fwd_lookup;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  l2_fwd_lookup_if bus();

  l2_fwd_lookup #(.IDX_W(4), .NUM_PORTS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  ip;
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [1:0]  gap;
    logic        clr;
    logic [7:0]  bm;
  } vec_t;

  vec_t         vecs [14];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [133:0] out_q [$];
  int           oc_q  [$];
  logic [133:0] tx_w  [6];
  int           tx_gap;
  logic         tx_clr;
  logic [7:0]   tx_bm;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.metadata_out_valid === 1'b1) begin
      out_q.push_back(bus.metadata_out);
      oc_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build(input vec_t v);
    tx_w[0] = {2'b01, 4'($urandom), rnd128()};
    tx_w[0][123:120] = v.ip;
    tx_w[1] = {2'b11, 4'($urandom), rnd128()};
    tx_w[1][127:80] = v.dmac;
    tx_w[1][79:32]  = v.smac;
    tx_w[2] = {2'b00, 4'($urandom), rnd128()};
    tx_w[3] = {2'b01, 4'($urandom), rnd128()};
    tx_w[4] = {2'b11, 4'($urandom), rnd128()};
    tx_w[5] = {2'b10, 4'($urandom), rnd128()};
    tx_gap = int'(v.gap);
    tx_clr = v.clr;
    tx_bm  = v.bm;
  endtask

  task automatic drive(input logic [133:0] w);
    bus.metadata_in_valid = 1'b1;
    bus.metadata_in       = w;
  endtask

  task automatic run_pkt(input string name);
    int           in_c [6];
    int           exp_c;
    logic [133:0] exp_w;
    out_q.delete();
    oc_q.delete();
    tick(); drive(tx_w[0]); in_c[0] = cyc;
    repeat (tx_gap) begin
      tick(); bus.metadata_in_valid = 1'b0;
    end
    tick(); drive(tx_w[1]); bus.tbl_clear = tx_clr; in_c[1] = cyc;
    for (int i = 2; i < 6; i++) begin
      tick(); drive(tx_w[i]); bus.tbl_clear = 1'b0; in_c[i] = cyc;
    end
    tick(); bus.metadata_in_valid = 1'b0; bus.tbl_clear = 1'b0;
    for (int k = 0; k < 20 && out_q.size() < 6; k++) tick();
    repeat (3) tick();
    checks++;
    if (out_q.size() != 6) begin
      errors++;
      $display("FAIL %s count: got %0d words want 6", name, out_q.size());
    end else begin
      chk($sformatf("%s bitmap", name), 134'(out_q[0][119:112]), 134'(tx_bm));
      for (int i = 0; i < 6; i++) begin
        exp_w = tx_w[i];
        if (i == 0) exp_w[119:112] = tx_bm;
        exp_c = (i == 0) ? in_c[1] + 1 : in_c[i] + 2;
        chk($sformatf("%s word%0d", name, i), out_q[i], exp_w);
        chk($sformatf("%s lat%0d", name, i), 134'(oc_q[i]), 134'(exp_c));
      end
    end
  endtask

  initial begin
    reset                 = 1'b0;
    bus.metadata_in_valid = 1'b0;
    bus.metadata_in       = '0;
    bus.ready_in          = 1'b0;
    bus.tbl_clear         = 1'b0;

    //          ip     dmac               smac               gap   clr   bitmap
    vecs[0]  = '{4'd2, 48'h001122334455, 48'h00aabbccdd03, 2'd0, 1'b0, 8'hFB};
    vecs[1]  = '{4'd5, 48'h00aabbccdd03, 48'h00aabbccdd05, 2'd0, 1'b0, 8'h04};
    vecs[2]  = '{4'd3, 48'h00aabbccdd05, 48'h00aabbccdd0f, 2'd0, 1'b0, 8'h20};
    vecs[3]  = '{4'd0, 48'hffffffffffff, 48'h00aabbccdd07, 2'd0, 1'b0, 8'hFE};
    vecs[4]  = '{4'd4, 48'h00aabbccdd0f, 48'h00aabbccdd09, 2'd2, 1'b0, 8'h08};
    vecs[5]  = '{4'd6, 48'h0000000000aa, 48'h01aabbccdd09, 2'd0, 1'b0, 8'hBF};
    vecs[6]  = '{4'd1, 48'h00aabbccdd09, 48'h00aabbccdd13, 2'd0, 1'b0, 8'h10};
    vecs[7]  = '{4'd6, 48'h00aabbccdd03, 48'h00aabbccdd21, 2'd0, 1'b0, 8'hBF};
    vecs[8]  = '{4'd1, 48'h00aabbccdd13, 48'h00aabbccdd31, 2'd0, 1'b0, 8'h00};
    vecs[9]  = '{4'd2, 48'h00aabbccdd0b, 48'h00aabbccdd0b, 2'd0, 1'b0, 8'hFB};
    vecs[10] = '{4'd3, 48'h00aabbccdd0b, 48'h00aabbccdd0c, 2'd0, 1'b0, 8'h04};
    vecs[11] = '{4'd5, 48'h00aabbccdd0b, 48'h00aabbccdd0d, 2'd1, 1'b1, 8'h04};
    vecs[12] = '{4'd0, 48'h00aabbccdd0b, 48'h00aabbccdd0e, 2'd0, 1'b0, 8'hFE};
    vecs[13] = '{4'd1, 48'h00aabbccdd0d, 48'h00aabbccdd1e, 2'd0, 1'b0, 8'h20};

    repeat (3) tick();
    chk("rst out_valid", 134'(bus.metadata_out_valid), 134'(0));
    chk("rst out_data", bus.metadata_out, 134'(0));
    chk("rst ready_out", 134'(bus.ready_out), 134'(1));

    reset = 1'b1;
    tick();
    chk("ready_out follows 0", 134'(bus.ready_out), 134'(0));
    bus.ready_in = 1'b1;
    tick();
    chk("ready_out follows 1", 134'(bus.ready_out), 134'(1));

    for (int v = 0; v < 14; v++) begin
      build(vecs[v]);
      run_pkt($sformatf("vec%0d", v));
    end

    // Idle clear pulse drops the entry learned by vec11.
    tick(); bus.tbl_clear = 1'b1;
    tick(); bus.tbl_clear = 1'b0;
    build('{4'd1, 48'h00aabbccdd0d, 48'h00aabbccdd04, 2'd0, 1'b0, 8'hFD});
    run_pkt("after_clear");

    // Word after word 0 tagged 00: flood, and its smac must not be learned.
    build('{4'd4, 48'h00aabbccdd22, 48'h00aabbccdd06, 2'd0, 1'b0, 8'hEF});
    tx_w[1][133:132] = 2'b00;
    run_pkt("malformed");
    build('{4'd0, 48'h00aabbccdd06, 48'h00aabbccdd08, 2'd0, 1'b0, 8'hFE});
    run_pkt("no_learn");

    // Reset in the middle of a packet.
    build('{4'd2, 48'h001122334455, 48'h00aabbccdd03, 2'd0, 1'b0, 8'hFB});
    tick(); drive(tx_w[0]);
    tick(); drive(tx_w[1]);
    tick(); drive(tx_w[2]);
    tick(); bus.metadata_in_valid = 1'b0; bus.ready_in = 1'b0; reset = 1'b0;
    tick();
    chk("midrst out_valid", 134'(bus.metadata_out_valid), 134'(0));
    chk("midrst out_data", bus.metadata_out, 134'(0));
    chk("midrst ready_out", 134'(bus.ready_out), 134'(1));
    reset = 1'b1; bus.ready_in = 1'b1;
    out_q.delete();
    oc_q.delete();
    repeat (8) tick();
    chk("midrst quiet", 134'(out_q.size()), 134'(0));
    build('{4'd2, 48'h001122334455, 48'h00aabbccdd03, 2'd0, 1'b0, 8'hFB});
    run_pkt("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
